// File: rtl/mole_gen.sv
// Whack-a-mole source: rolls the lit hole, runs the game clock,
// and drives the seq/stop pair consumed by the scorer.
module mole_gen #(
    parameter int unsigned CLK_DIV       = 12500000,
    parameter int unsigned TICKS_PER_SEC = 4,
    parameter int unsigned HOLD_TICKS    = 3,
    parameter int unsigned GAME_SECS     = 60,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] button,
    output logic [1:0] seq,
    output logic       stop,
    output logic [3:0] led,
    output logic [6:0] disp_ts,
    output logic [6:0] disp_tg
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [3:0] G_TENS = 4'(GAME_SECS / 10);
    localparam logic [3:0] G_ONES = 4'(GAME_SECS % 10);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    state_t      state;
    logic        start_s1, start_s2, start_d;
    logic [1:0]  btn_s1, btn_s2;
    logic        match_d;
    logic [7:0]  lfsr;
    logic [3:0]  tens, ones;
    logic [PW-1:0] pre;
    logic [TW-1:0] tcnt;
    logic [HW-1:0] hold;

    logic        start_edge, match, hit, tick, sec, expire, advance;
    logic [7:0]  lfsr_next;
    logic [1:0]  cand, seq_next;
    logic [3:0]  tens_dec, ones_dec;
    logic        time_zero;

    assign start_edge = start_s2 & ~start_d;
    assign match      = (btn_s2 == seq);
    assign hit        = match & ~match_d & (state == RUN);
    assign tick       = (state == RUN) && (pre == PW'(CLK_DIV - 1));
    assign sec        = tick && (tcnt == TW'(TICKS_PER_SEC - 1));
    assign expire     = tick && (hold == HW'(HOLD_TICKS - 1));
    assign advance    = hit | expire;

    // Next hole must differ from the current one so a held press scores once.
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign cand      = lfsr_next[1:0];
    assign seq_next  = (cand == seq) ? seq + 2'd1 : cand;

    always_comb begin
        tens_dec = tens;
        ones_dec = ones - 4'd1;
        if (ones == 4'd0) begin
            tens_dec = tens - 4'd1;
            ones_dec = 4'd9;
        end
    end

    assign time_zero = (tens_dec == 4'd0) && (ones_dec == 4'd0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            seq      <= 2'd0;
            stop     <= 1'b1;
            led      <= 4'b0000;
            tens     <= G_TENS;
            ones     <= G_ONES;
            lfsr     <= LFSR_SEED;
            pre      <= '0;
            tcnt     <= '0;
            hold     <= '0;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
            btn_s1   <= 2'd0;
            btn_s2   <= 2'd0;
            match_d  <= 1'b0;
            disp_ts  <= seg7(G_TENS);
            disp_tg  <= seg7(G_ONES);
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            btn_s1   <= button;
            btn_s2   <= btn_s1;
            match_d  <= match;
            disp_ts  <= seg7(tens);
            disp_tg  <= seg7(ones);
            unique case (state)
                IDLE, OVER: begin
                    if (start_edge) begin
                        state <= RUN;
                        stop  <= 1'b0;
                        tens  <= G_TENS;
                        ones  <= G_ONES;
                        pre   <= '0;
                        tcnt  <= '0;
                        hold  <= '0;
                        lfsr  <= lfsr_next;
                        seq   <= seq_next;
                        led   <= 4'b0001 << seq_next;
                    end
                end
                RUN: begin
                    pre <= tick ? '0 : pre + 1'b1;
                    if (tick)
                        tcnt <= sec ? '0 : tcnt + 1'b1;
                    if (sec) begin
                        tens <= tens_dec;
                        ones <= ones_dec;
                    end
                    // Game end outranks any same-cycle mole advance.
                    if (sec && time_zero) begin
                        state <= OVER;
                        stop  <= 1'b1;
                        led   <= 4'b1111;
                    end else if (advance) begin
                        hold <= '0;
                        lfsr <= lfsr_next;
                        seq  <= seq_next;
                        led  <= 4'b0001 << seq_next;
                    end else if (tick) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_gen.sv
// Scoreboard bench for mole_gen: stimulus queues expected hole and
// display changes, monitors pop and compare when the outputs move.
module tb_mole_gen;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic [1:0] button = 2'd3;
    logic [1:0] seq;
    logic       stop;
    logic [3:0] led;
    logic [6:0] disp_ts, disp_tg;

    mole_gen #(
        .CLK_DIV(4),
        .TICKS_PER_SEC(2),
        .HOLD_TICKS(3),
        .GAME_SECS(12),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk),
        .clr(clr),
        .start(start),
        .button(button),
        .seq(seq),
        .stop(stop),
        .led(led),
        .disp_ts(disp_ts),
        .disp_tg(disp_tg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] s;
        int         gap;
        logic [3:0] l;
    } seq_exp_t;

    typedef struct {
        int val;
        int gap;
    } dsp_exp_t;

    seq_exp_t seq_q[$];
    dsp_exp_t dsp_q[$];

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_seq(input logic [1:0] s, input int gap);
        seq_exp_t e;
        e.s = s;
        e.gap = gap;
        e.l = 4'b0001 << s;
        seq_q.push_back(e);
    endtask

    task automatic push_dsp(input int v, input int gap);
        dsp_exp_t e;
        e.val = v;
        e.gap = gap;
        dsp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_game(output int e);
        int p;
        p = cyc;
        e = -1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (stop === 1'b0) begin
                e = cyc;
                break;
            end
        end
        start = 1'b0;
        if (e < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL start_timeout: stop still %b after 6 cycles", stop);
            e = cyc;
        end else begin
            check("start_latency", 32'(e - p), 32'd3);
        end
    endtask

    // Hole monitor
    logic [1:0] seq_prev = 2'd0;
    int         seq_last = 0;
    initial begin
        seq_exp_t e;
        forever begin
            @(negedge clk);
            if (seq !== seq_prev) begin
                if (seq_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL seq_unexpected: got %0d, none expected (cycle %0d)",
                             seq, cyc);
                end else begin
                    e = seq_q.pop_front();
                    check("seq", 32'(seq), 32'(e.s));
                    check("led", 32'(led), 32'(e.l));
                    if (e.gap != 0)
                        check("seq_gap", 32'(cyc - seq_last), 32'(e.gap));
                end
                seq_prev = seq;
                seq_last = cyc;
            end
        end
    end

    // Display monitor
    logic [13:0] dsp_prev = {7'b1111001, 7'b0100100};
    int          dsp_last = 0;
    initial begin
        dsp_exp_t e;
        forever begin
            @(negedge clk);
            if ({disp_ts, disp_tg} !== dsp_prev) begin
                if (dsp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL disp_unexpected: got %b_%b, none expected (cycle %0d)",
                             disp_ts, disp_tg, cyc);
                end else begin
                    e = dsp_q.pop_front();
                    check("disp_ts", 32'(disp_ts), 32'(seg(e.val / 10)));
                    check("disp_tg", 32'(disp_tg), 32'(seg(e.val % 10)));
                    if (e.gap != 0)
                        check("disp_gap", 32'(cyc - dsp_last), 32'(e.gap));
                end
                dsp_prev = {disp_ts, disp_tg};
                dsp_last = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2, e3;
        #2 clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;

        // Idle: nothing moves for 200 cycles
        wait_to(210);
        check("idle_stop", 32'(stop), 32'd1);
        check("idle_led", 32'(led), 32'd0);
        check("idle_seq", 32'(seq), 32'd0);
        check("idle_ts", 32'(disp_ts), 32'(7'b1111001));
        check("idle_tg", 32'(disp_tg), 32'(7'b0100100));

        // Game 1: button parked on hole 3, hit when the mole lands there
        push_seq(2'd2, 0);
        push_seq(2'd1, 12);
        push_seq(2'd2, 12);
        push_seq(2'd0, 12);
        push_seq(2'd1, 12);
        push_seq(2'd3, 12);
        push_seq(2'd0, 1);
        push_seq(2'd2, 11);
        push_seq(2'd1, 12);
        push_dsp(11, 0);
        for (int v = 10; v >= 0; v--) push_dsp(v, 8);
        start_game(e0);
        wait_to(e0 + 30);
        start = 1'b1;
        wait_to(e0 + 34);
        start = 1'b0;
        wait_to(e0 + 95);
        check("g1_running", 32'(stop), 32'd0);
        wait_to(e0 + 97);
        check("g1_over_stop", 32'(stop), 32'd1);
        check("g1_over_led", 32'(led), 32'hF);
        check("g1_over_ts", 32'(disp_ts), 32'(seg(0)));
        check("g1_over_tg", 32'(disp_tg), 32'(seg(0)));
        wait_to(e0 + 200);
        check("g1_seq_frozen", 32'(seq), 32'd1);

        // Game 2: restart from OVER, mid-hold hit, hit on expiry, hit on last sec
        button = 2'd0;
        push_seq(2'd3, 0);
        push_seq(2'd0, 8);
        push_seq(2'd2, 12);
        push_seq(2'd1, 12);
        push_seq(2'd3, 12);
        push_seq(2'd2, 1);
        push_seq(2'd0, 11);
        push_seq(2'd1, 12);
        push_seq(2'd3, 12);
        push_seq(2'd0, 12);
        push_dsp(12, 0);
        for (int v = 11; v >= 0; v--) push_dsp(v, 8);
        start_game(e1);
        wait_to(e1 + 5);
        button = 2'd3;
        wait_to(e1 + 65);
        button = 2'd0;
        wait_to(e1 + 82);
        button = 2'd2;
        wait_to(e1 + 93);
        button = 2'd0;
        wait_to(e1 + 95);
        check("g2_running", 32'(stop), 32'd0);
        wait_to(e1 + 97);
        check("g2_over_stop", 32'(stop), 32'd1);
        check("g2_over_led", 32'(led), 32'hF);
        check("g2_over_ts", 32'(disp_ts), 32'(seg(0)));
        check("g2_over_tg", 32'(disp_tg), 32'(seg(0)));
        wait_to(e1 + 200);
        check("g2_seq_frozen", 32'(seq), 32'd0);

        // Game 3: one-cycle reset in the middle of a game
        push_seq(2'd3, 0);
        begin
            seq_exp_t r;
            r.s = 2'd0;
            r.gap = 0;
            r.l = 4'b0000;
            seq_q.push_back(r);
        end
        push_dsp(12, 0);
        start_game(e2);
        wait_to(e2 + 6);
        clr = 1'b0;
        wait_to(e2 + 7);
        clr = 1'b1;
        check("rst_stop", 32'(stop), 32'd1);
        check("rst_led", 32'(led), 32'd0);
        check("rst_seq", 32'(seq), 32'd0);
        check("rst_ts", 32'(disp_ts), 32'(seg(1)));
        check("rst_tg", 32'(disp_tg), 32'(seg(2)));

        // Game 4: reseeded LFSR replays the sequence from the top
        wait_to(e2 + 20);
        push_seq(2'd2, 0);
        push_seq(2'd1, 12);
        push_seq(2'd2, 12);
        push_seq(2'd0, 12);
        push_seq(2'd1, 1);
        push_dsp(11, 0);
        push_dsp(10, 8);
        push_dsp(9, 8);
        push_dsp(8, 8);
        start_game(e3);
        wait_to(e3 + 40);
        check("seq_q_drained", 32'(seq_q.size()), 32'd0);
        check("dsp_q_drained", 32'(dsp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_gen.md
Name: mole_gen

Overview:
- Whack-a-mole "mole" source: picks which of 4 holes is lit, holds it for a fixed time, and re-rolls it early on a hit.
- Runs a game countdown and drives the 2-bit `seq` and the `stop` flag that the score counter consumes.
- Shows remaining seconds on two 7-segment digits (tens, ones).
- Sits between the board buttons/LEDs and the scoring block; shares `button[1:0]` with the scorer.

Parameters:
- CLK_DIV, 12500000, clk cycles per game tick (0.25 s at 50 MHz).
- TICKS_PER_SEC, 4, ticks per countdown second.
- HOLD_TICKS, 3, ticks a mole stays lit without a hit.
- GAME_SECS, 60, game length in seconds; legal range 1..99.
- LFSR_SEED, 8'hA5, reset/restart LFSR value; must be non-zero.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-low reset.
- start  in  1  start/restart key, asynchronous, active-high.
- button  in  2  player's hole selection, asynchronous level.
- seq  out  2  current mole hole index (0..3).
- stop  out  1  1 = game not running (scoring must be blocked).
- led  out  4  hole lamps, one-hot, active-high.
- disp_ts  out  7  remaining-time tens digit, active-low segments g..a.
- disp_tg  out  7  remaining-time ones digit, active-low segments g..a.

Behaviour:
- Reset (clr=0, asynchronous) forces:
  - state IDLE, seq=0, stop=1, led=0;
  - time BCD = GAME_SECS (tens/ones), LFSR=LFSR_SEED;
  - prescaler, tick counter and hold counter = 0;
  - sync/edge registers = 0.
- Input conditioning:
  - `start` and `button` each pass through a 2-FF synchroniser.
  - start_edge = rising edge of synced start.
  - match = (synced button == seq); hit = rising edge of match, only in RUN.
- States: IDLE, RUN, OVER. Outputs are registered.
- IDLE: stop=1, led=0, display shows GAME_SECS. start_edge -> RUN.
- Entering RUN (from IDLE or OVER):
  - reload time to GAME_SECS; clear prescaler, tick counter and hold counter;
  - step LFSR once and load the new mole (rule below).
  - stop goes 0 on the cycle after start_edge is registered.
- RUN, prescaler:
  - counts 0..CLK_DIV-1; tick = 1-cycle pulse at wrap.
  - tick counter counts ticks 0..TICKS_PER_SEC-1; sec = tick at last count.
- RUN, countdown:
  - on sec, decrement BCD time: ones 0 -> 9 with tens-1, otherwise ones-1.
  - when the decrement yields 00 -> OVER on that same clock edge.
- RUN, mole advance: occurs on hit, or on tick when hold counter == HOLD_TICKS-1; otherwise the hold counter increments on each tick.
  - Advance steps: hold counter = 0; LFSR steps once (8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit0).
  - new seq = LFSR_next[1:0], or (seq+1) mod 4 if that equals the current seq. The new hole always differs, so match falls and a single press scores at most once.
  - hit and hold expiry in the same cycle -> exactly one advance.
- led = one-hot(seq) in RUN, 4'b0000 in IDLE, 4'b1111 in OVER.
- OVER:
  - stop=1, seq frozen, time shows 00.
  - If a sec decrement to 00 and a hit land on the same cycle, OVER wins; no advance.
  - start_edge -> RUN (full restart, as above).
- start_edge while in RUN is ignored.
- clr low mid-game -> immediate IDLE with reset values; no partial state survives.
- 7-segment (active-low gfedcba) encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - any non-BCD value = 1111111.
- Display decode is combinational from the time registers and registered at the output (1-cycle latency).

Test Plan (bench parameters: CLK_DIV=4, TICKS_PER_SEC=2, HOLD_TICKS=3, GAME_SECS=12):
- Reset then idle 200 cycles -> stop=1, led=0, disp_ts=1111001, disp_tg=0100100; no state change.
- start pulse, no buttons -> RUN within 4 cycles (sync+edge), stop=0; seq changes exactly every 12 clk cycles; every new seq differs from the previous one; led stays one-hot.
- Countdown -> time 12, 11, 10, 09, ..., 01, 00 at 8-cycle spacing (10->09 checks the BCD borrow); at 00, stop=1 and led=1111; seq holds over the next 100 cycles.
- Drive button=seq mid-hold -> seq changes within 4 cycles of the press and the hold counter restarts (next timeout 12 cycles later). Holding the button constant afterwards gives no further advance until the mole wraps back.
- Corner: hit synchronised on the same cycle as the hold-expiry tick -> exactly one LFSR step; hit on the final sec edge -> OVER, seq unchanged.
- Reset mid-RUN with clr=0 for 1 cycle -> IDLE, seq=0, display 12, LFSR=A5; then start from OVER -> restart at 12 with stop=0.
